// File: rtl/debug_bridge_pkg.sv
// ============================================================================
// Module      : debug_bridge_pkg
// Description : Register map, bit positions and FSM encoding shared by the
//               JTAG debug-port to memory-bus bridge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package debug_bridge_pkg;

  localparam logic [2:0] REG_ADDR    = 3'd0;
  localparam logic [2:0] REG_DATA    = 3'd1;
  localparam logic [2:0] REG_CMD     = 3'd2;
  localparam logic [2:0] REG_STATUS  = 3'd3;
  localparam logic [2:0] REG_CTRL    = 3'd4;
  localparam logic [2:0] REG_SCRATCH = 3'd5;

  localparam int STATUS_BUSY_BIT  = 0;
  localparam int STATUS_TMO_BIT   = 1;
  localparam int STATUS_OVR_BIT   = 2;
  localparam int STATUS_CNT_LSB   = 16;
  localparam int CTRL_AUTOINC_BIT = 0;
  localparam int CMD_READ_BIT     = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } bridge_state_t;

endpackage

`default_nettype wire

// File: rtl/debug_bus_bridge.sv
// ============================================================================
// Module      : debug_bus_bridge
// Description : Debug strobe-port register bank that issues single-beat
//               req/ack bus transactions. Define DEBUG_BRIDGE_TIMEOUT_EN to
//               build the ack timeout counter and STATUS timeout flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debug_bus_bridge
  import debug_bridge_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_rd,
  input  logic        i_wr,
  input  logic [2:0]  i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  output logic        o_bus_rd,
  output logic        o_bus_wr,
  input  logic [31:0] i_bus_rdata,
  input  logic        i_bus_ack
);

  bridge_state_t r_state;
  bridge_state_t w_state_nxt;

  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [31:0] r_scratch;
  logic [31:0] r_rdata_out;
  logic [15:0] r_count;
  logic        r_autoinc;
  logic        r_overrun;

  logic        w_busy;
  logic        w_ack;
  logic        w_timeout;
  logic        w_tmo_err;
  logic        w_start_wr;
  logic        w_start_rd;
  logic        w_blocked_wr;
  logic        w_status_wr;
  logic [31:0] w_status;
  logic [31:0] w_rd_mux;

  assign w_busy       = (r_state != IDLE);
  assign w_ack        = w_busy & i_bus_ack;
  assign w_start_wr   = ~w_busy & i_wr & (i_addr == REG_DATA);
  assign w_start_rd   = ~w_busy & i_wr & (i_addr == REG_CMD) & i_wdata[CMD_READ_BIT];
  assign w_blocked_wr = w_busy & i_wr &
                        (i_addr inside {REG_ADDR, REG_DATA, REG_CMD, REG_CTRL});
  assign w_status_wr  = i_wr & (i_addr == REG_STATUS);

`ifdef DEBUG_BRIDGE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_tmo_err;

  // Counts request-asserted cycles; expiry on the TIMEOUT-th cycle unless acked.
  assign w_timeout = w_busy & ~i_bus_ack & (r_tmo_cnt == TMO_LAST);
  assign w_tmo_err = r_tmo_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tmo_cnt <= '0;
      r_tmo_err <= 1'b0;
    end else begin
      if (!w_busy) r_tmo_cnt <= '0;
      else         r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
      if (w_timeout)
        r_tmo_err <= 1'b1;
      else if (w_status_wr && i_wdata[STATUS_TMO_BIT])
        r_tmo_err <= 1'b0;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign w_tmo_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_start_wr)      w_state_nxt = WRITE;
        else if (w_start_rd) w_state_nxt = READ;
      end
      WRITE, READ: begin
        if (i_bus_ack || w_timeout) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_status = {r_count, 13'd0, r_overrun, w_tmo_err, w_busy};

  always_comb begin
    w_rd_mux = 32'd0;
    case (i_addr)
      REG_ADDR:    w_rd_mux = r_addr;
      REG_DATA:    w_rd_mux = r_rdata;
      REG_STATUS:  w_rd_mux = w_status;
      REG_CTRL:    w_rd_mux = {31'd0, r_autoinc};
      REG_SCRATCH: w_rd_mux = r_scratch;
      default:     w_rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_scratch   <= '0;
      r_rdata_out <= '0;
      r_count     <= '0;
      r_autoinc   <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      // Mux uses pre-edge values, so a same-cycle write is not reflected.
      if (i_rd) r_rdata_out <= w_rd_mux;

      if (i_wr && !w_busy) begin
        case (i_addr)
          REG_ADDR: r_addr    <= i_wdata;
          REG_DATA: r_wdata   <= i_wdata;
          REG_CTRL: r_autoinc <= i_wdata[CTRL_AUTOINC_BIT];
          default:  ;
        endcase
      end

      if (i_wr && i_addr == REG_SCRATCH) r_scratch <= i_wdata;

      if (w_blocked_wr)
        r_overrun <= 1'b1;
      else if (w_status_wr && i_wdata[STATUS_OVR_BIT])
        r_overrun <= 1'b0;

      // ADDR writes are blocked while busy, so this never races the write above.
      if (w_ack) begin
        r_count <= r_count + 16'd1;
        if (r_state == READ) r_rdata <= i_bus_rdata;
        if (r_autoinc)       r_addr  <= r_addr + 32'd4;
      end
    end
  end

  assign o_rdata     = r_rdata_out;
  assign o_bus_addr  = r_addr;
  assign o_bus_wdata = r_wdata;
  assign o_bus_wr    = (r_state == WRITE);
  assign o_bus_rd    = (r_state == READ);

endmodule

`default_nettype wire

// File: tb/tb_debug_bus_bridge.sv
// ============================================================================
// Module      : tb_debug_bus_bridge
// Description : Directed self-checking bench for debug_bus_bridge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_debug_bus_bridge;

  logic        clk;
  logic        reset;
  logic        i_rd;
  logic        i_wr;
  logic [2:0]  i_addr;
  logic [31:0] i_wdata;
  logic [31:0] o_rdata;
  logic [31:0] o_bus_addr;
  logic [31:0] o_bus_wdata;
  logic        o_bus_rd;
  logic        o_bus_wr;
  logic [31:0] i_bus_rdata;
  logic        i_bus_ack;

  int n_checks = 0;
  int n_errors = 0;

  debug_bus_bridge #(.TIMEOUT(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_rd        (i_rd),
    .i_wr        (i_wr),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .o_rdata     (o_rdata),
    .o_bus_addr  (o_bus_addr),
    .o_bus_wdata (o_bus_wdata),
    .o_bus_rd    (o_bus_rd),
    .o_bus_wr    (o_bus_wr),
    .i_bus_rdata (i_bus_rdata),
    .i_bus_ack   (i_bus_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    i_wr = 1'b1; i_addr = a; i_wdata = d;
    @(negedge clk);
    i_wr = 1'b0;
  endtask

  task automatic reg_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    i_rd = 1'b1; i_addr = a;
    @(negedge clk);
    i_rd = 1'b0;
    d = o_rdata;
  endtask

  task automatic reg_rw(input logic [2:0] a, input logic [31:0] wd, output logic [31:0] rd);
    @(negedge clk);
    i_rd = 1'b1; i_wr = 1'b1; i_addr = a; i_wdata = wd;
    @(negedge clk);
    i_rd = 1'b0; i_wr = 1'b0;
    rd = o_rdata;
  endtask

  task automatic bus_ack(input logic [31:0] d);
    @(negedge clk);
    i_bus_ack = 1'b1; i_bus_rdata = d;
    @(negedge clk);
    i_bus_ack = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    logic [15:0] exp_cnt;
    logic [31:0] exp_addr;
    logic [31:0] exp_rdata;
    int n;

    reset = 1'b1; i_rd = 1'b0; i_wr = 1'b0; i_addr = 3'd0; i_wdata = 32'd0;
    i_bus_rdata = 32'd0; i_bus_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rdata", o_rdata, 32'd0);
    chk("rst_bus_wr", {31'd0, o_bus_wr}, 32'd0);
    chk("rst_bus_rd", {31'd0, o_bus_rd}, 32'd0);
    reset = 1'b0;
    reg_read(3'd3, v); chk("rst_status", v, 32'd0);
    reg_read(3'd0, v); chk("rst_addr", v, 32'd0);

    // Plain bus write, acked after three request cycles
    reg_write(3'd0, 32'h0000_1000);
    reg_write(3'd1, 32'hDEAD_BEEF);
    chk("wr_req", {31'd0, o_bus_wr}, 32'd1);
    chk("wr_no_rd", {31'd0, o_bus_rd}, 32'd0);
    chk("wr_addr", o_bus_addr, 32'h0000_1000);
    chk("wr_wdata", o_bus_wdata, 32'hDEAD_BEEF);
    @(negedge clk);
    bus_ack(32'd0);
    chk("wr_req_drop", {31'd0, o_bus_wr}, 32'd0);
    reg_read(3'd3, v); chk("wr_status", v, 32'h0001_0000);

    // Autoincrementing bus read
    reg_write(3'd4, 32'h0000_0001);
    reg_write(3'd0, 32'h0000_2000);
    reg_write(3'd2, 32'h0000_0001);
    chk("rd_req", {31'd0, o_bus_rd}, 32'd1);
    chk("rd_addr", o_bus_addr, 32'h0000_2000);
    reg_read(3'd3, v); chk("busy_status", v, 32'h0001_0001);
    bus_ack(32'h1234_5678);
    chk("rd_req_drop", {31'd0, o_bus_rd}, 32'd0);
    reg_read(3'd1, v); chk("rd_data", v, 32'h1234_5678);
    reg_read(3'd0, v); chk("rd_autoinc", v, 32'h0000_2004);
    reg_read(3'd2, v); chk("cmd_reads0", v, 32'd0);
    reg_read(3'd4, v); chk("ctrl_rd", v, 32'd1);

    // Address wrap on autoincrement
    reg_write(3'd0, 32'hFFFF_FFFC);
    reg_write(3'd1, 32'h0000_0055);
    bus_ack(32'd0);
    reg_read(3'd0, v); chk("addr_wrap", v, 32'd0);
    reg_read(3'd3, v); chk("cnt3", v, 32'h0003_0000);

    // Read with no ack
    reg_write(3'd2, 32'h0000_0001);
`ifdef DEBUG_BRIDGE_TIMEOUT_EN
    n = 0;
    while (o_bus_rd && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("tmo_cycles", n, 16);
    exp_cnt = 16'd3; exp_addr = 32'd0; exp_rdata = 32'h1234_5678;
    reg_read(3'd3, v); chk("tmo_status", v, {exp_cnt, 16'h0002});
    reg_write(3'd3, 32'h0000_0002);
    reg_read(3'd3, v); chk("tmo_w1c", v, {exp_cnt, 16'h0000});
`else
    n = 0;
    repeat (40) @(negedge clk);
    chk("no_tmo_req", {31'd0, o_bus_rd}, 32'd1);
    reg_read(3'd3, v); chk("no_tmo_bit", v & 32'h2, 32'd0);
    bus_ack(32'hA5A5_A5A5);
    exp_cnt = 16'd4; exp_addr = 32'd4; exp_rdata = 32'hA5A5_A5A5;
`endif
    reg_read(3'd0, v); chk("post_addr", v, exp_addr);
    reg_read(3'd1, v); chk("post_rdata", v, exp_rdata);

    // Overrun while busy
    reg_write(3'd4, 32'd0);
    reg_write(3'd0, 32'h0000_3000);
    reg_write(3'd1, 32'h0000_0011);
    reg_write(3'd1, 32'h0000_0022);
    chk("ovr_wdata", o_bus_wdata, 32'h0000_0011);
    reg_write(3'd0, 32'h0000_4444);
    chk("ovr_addr", o_bus_addr, 32'h0000_3000);
    reg_write(3'd5, 32'hCAFE_F00D);
    reg_read(3'd3, v); chk("ovr_status", v, {exp_cnt, 16'h0005});
    bus_ack(32'd0);
    chk("ovr_done", {31'd0, o_bus_wr}, 32'd0);
    @(negedge clk);
    chk("ovr_no_2nd", {30'd0, o_bus_wr, o_bus_rd}, 32'd0);
    reg_read(3'd3, v); chk("ovr_sticky", v, {exp_cnt + 16'd1, 16'h0004});
    reg_write(3'd3, 32'h0000_0004);
    reg_read(3'd3, v); chk("ovr_w1c", v, {exp_cnt + 16'd1, 16'h0000});
    reg_read(3'd5, v); chk("scratch_busy", v, 32'hCAFE_F00D);

    // Same-cycle read and write returns the old value
    reg_rw(3'd5, 32'h0000_0001, v); chk("rw_old", v, 32'hCAFE_F00D);
    reg_read(3'd5, v); chk("rw_new", v, 32'h0000_0001);

    // Stray ack and unmapped registers
    bus_ack(32'hFFFF_FFFF);
    reg_read(3'd3, v); chk("idle_ack", v, {exp_cnt + 16'd1, 16'h0000});
    reg_write(3'd6, 32'hFFFF_FFFF);
    reg_read(3'd6, v); chk("reg6", v, 32'd0);
    reg_read(3'd7, v); chk("reg7", v, 32'd0);

    // Asynchronous reset mid-transaction
    reg_write(3'd4, 32'd1);
    reg_write(3'd1, 32'h0000_0077);
    chk("pre_rst_req", {31'd0, o_bus_wr}, 32'd1);
    #2 reset = 1'b1;
    #1 chk("async_drop", {31'd0, o_bus_wr}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    reg_read(3'd0, v); chk("rst2_addr", v, 32'd0);
    reg_read(3'd1, v); chk("rst2_data", v, 32'd0);
    reg_read(3'd3, v); chk("rst2_status", v, 32'd0);
    reg_read(3'd4, v); chk("rst2_ctrl", v, 32'd0);
    reg_read(3'd5, v); chk("rst2_scratch", v, 32'd0);
    chk("rst2_wdata", o_bus_wdata, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
